// File: rtl/ethernet_tx_frame_buffer.sv
// ethernet_tx_frame_buffer
//   Store-and-forward transmit buffer between the L2 frame encoder and the MAC.
//   Frames are written into a data RAM and released to the MAC only after they
//   have been committed, so a started frame always streams out without gaps.
//   Dropped, overflowed and zero-length frames are rolled back and never sent.
//
// Ports
//   clk, rst_n                    single clock, asynchronous active-low reset
//   in_start                      start of a new frame (discards any uncommitted one)
//   in_data_valid                 in_data / in_bytes_valid carry a word
//   in_bytes_valid[2:0]           valid bytes in the word (1..4, MSB first)
//   in_data[31:0]                 frame data
//   in_commit                     current frame complete, queue it for transmit
//   in_drop                       discard the current frame
//   tx_ready                      MAC can accept a new frame start
//   tx_start                      one-cycle start-of-frame strobe
//   tx_data_valid                 tx_data / tx_bytes_valid valid
//   tx_bytes_valid[2:0]           valid bytes in tx_data
//   tx_data[31:0]                 frame data to the MAC
//   buf_free[log2(DEPTH):0]       free words, counting uncommitted data
//   frames_pending[log2(FD):0]    committed frames not yet started
//   perf_tx_frames[63:0]          frames fully sent
//   perf_tx_dropped[63:0]         frames discarded

module ethernet_tx_frame_buffer #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned FRAME_DEPTH = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_start,
    input  logic                           in_data_valid,
    input  logic [2:0]                     in_bytes_valid,
    input  logic [31:0]                    in_data,
    input  logic                           in_commit,
    input  logic                           in_drop,
    input  logic                           tx_ready,
    output logic                           tx_start,
    output logic                           tx_data_valid,
    output logic [2:0]                     tx_bytes_valid,
    output logic [31:0]                    tx_data,
    output logic [$clog2(DEPTH):0]         buf_free,
    output logic [$clog2(FRAME_DEPTH):0]   frames_pending,
    output logic [63:0]                    perf_tx_frames,
    output logic [63:0]                    perf_tx_dropped
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned FW = $clog2(FRAME_DEPTH);

    typedef logic [AW:0] ptr_t;
    typedef logic [FW:0] fptr_t;
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA} state_t;

    logic [34:0] ram    [DEPTH];
    ptr_t        lf_mem [FRAME_DEPTH];
    logic [34:0] rd_q;

    ptr_t   wr_ptr, commit_ptr, rd_ptr, word_cnt, len_left;
    logic   overflow;
    fptr_t  lf_wr, lf_rd;
    state_t state;

    ptr_t   wp_base, cnt_base, wp_next, cnt_next, wr_nxt, rd_nxt;
    logic   ovf_base, ovf_next, is_full, do_write, lf_full, lf_empty;
    logic   commit_ok, drop_event, start_discard, pop, ren;
    fptr_t  lf_wr_nxt, lf_rd_nxt;

    // Write side: in_start rebases the frame onto commit_ptr before the
    // same-cycle data word, commit and drop are applied.
    always_comb begin
        wp_base       = in_start ? commit_ptr : wr_ptr;
        cnt_base      = in_start ? '0 : word_cnt;
        ovf_base      = in_start ? 1'b0 : overflow;
        is_full       = (wp_base - rd_ptr) == ptr_t'(DEPTH);
        do_write      = in_data_valid && !is_full;
        wp_next       = do_write ? wp_base + ptr_t'(1) : wp_base;
        cnt_next      = do_write ? cnt_base + ptr_t'(1) : cnt_base;
        ovf_next      = ovf_base || (in_data_valid && is_full);
        lf_full       = (lf_wr - lf_rd) == fptr_t'(FRAME_DEPTH);
        lf_empty      = (lf_wr == lf_rd);
        commit_ok     = in_commit && !in_drop && !ovf_next && (cnt_next != '0) && !lf_full;
        drop_event    = in_drop || (in_commit && !commit_ok);
        start_discard = in_start && (wr_ptr != commit_ptr);
        wr_nxt        = (drop_event && !commit_ok) ? commit_ptr : wp_next;

        pop           = (state == S_IDLE) && !lf_empty && tx_ready;
        // START holds the full length L; DATA holds the words still to emit.
        ren           = pop || ((state != S_IDLE) && (len_left > ptr_t'(1)));
        rd_nxt        = ren ? rd_ptr + ptr_t'(1) : rd_ptr;
        lf_wr_nxt     = commit_ok ? lf_wr + fptr_t'(1) : lf_wr;
        lf_rd_nxt     = pop ? lf_rd + fptr_t'(1) : lf_rd;
    end

    // Storage: data RAM with registered read, length FIFO memory.
    always_ff @(posedge clk) begin
        if (do_write)
            ram[wp_base[AW-1:0]] <= {in_bytes_valid, in_data};
        if (ren)
            rd_q <= ram[rd_ptr[AW-1:0]];
        if (commit_ok)
            lf_mem[lf_wr[FW-1:0]] <= cnt_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr          <= '0;
            commit_ptr      <= '0;
            word_cnt        <= '0;
            overflow        <= 1'b0;
            lf_wr           <= '0;
            perf_tx_dropped <= '0;
        end else begin
            wr_ptr          <= wr_nxt;
            lf_wr           <= lf_wr_nxt;
            if (commit_ok)
                commit_ptr <= wp_next;
            word_cnt        <= (commit_ok || drop_event) ? '0 : cnt_next;
            overflow        <= (commit_ok || drop_event) ? 1'b0 : ovf_next;
            perf_tx_dropped <= perf_tx_dropped + 64'(start_discard) + 64'(drop_event);
        end
    end

    // Read FSM. The RAM read is issued one cycle ahead of each output word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            rd_ptr         <= '0;
            lf_rd          <= '0;
            len_left       <= '0;
            tx_start       <= 1'b0;
            tx_data_valid  <= 1'b0;
            tx_bytes_valid <= '0;
            tx_data        <= '0;
            perf_tx_frames <= '0;
            buf_free       <= ptr_t'(DEPTH);
            frames_pending <= '0;
        end else begin
            rd_ptr         <= rd_nxt;
            lf_rd          <= lf_rd_nxt;
            buf_free       <= ptr_t'(DEPTH) - (wr_nxt - rd_nxt);
            frames_pending <= lf_wr_nxt - lf_rd_nxt;
            case (state)
                S_IDLE: begin
                    tx_data_valid  <= 1'b0;
                    tx_bytes_valid <= '0;
                    tx_data        <= '0;
                    if (pop) begin
                        len_left <= lf_mem[lf_rd[FW-1:0]];
                        tx_start <= 1'b1;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    tx_start                  <= 1'b0;
                    tx_data_valid             <= 1'b1;
                    {tx_bytes_valid, tx_data} <= rd_q;
                    len_left                  <= len_left - ptr_t'(1);
                    state                     <= S_DATA;
                end
                default: begin
                    if (len_left == '0) begin
                        tx_data_valid  <= 1'b0;
                        tx_bytes_valid <= '0;
                        tx_data        <= '0;
                        perf_tx_frames <= perf_tx_frames + 64'd1;
                        state          <= S_IDLE;
                    end else begin
                        {tx_bytes_valid, tx_data} <= rd_q;
                        len_left                  <= len_left - ptr_t'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ethernet_tx_frame_buffer.sv
// tb_ethernet_tx_frame_buffer
//   Directed bench: a DEPTH=1024 instance for the main scenarios and a
//   DEPTH=64 instance for the overflow scenario, both on shared inputs.

module tb_ethernet_tx_frame_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_start, in_data_valid, in_commit, in_drop, tx_ready;
    logic [2:0]  in_bytes_valid;
    logic [31:0] in_data;

    logic        tx_start, tx_data_valid;
    logic [2:0]  tx_bytes_valid;
    logic [31:0] tx_data;
    logic [10:0] buf_free;
    logic [5:0]  frames_pending;
    logic [63:0] perf_tx_frames, perf_tx_dropped;

    logic        s_tx_start, s_tx_data_valid;
    logic [2:0]  s_tx_bytes_valid;
    logic [31:0] s_tx_data;
    logic [6:0]  s_buf_free;
    logic [2:0]  s_frames_pending;
    logic [63:0] s_perf_tx_frames, s_perf_tx_dropped;

    always #5 clk = ~clk;

    ethernet_tx_frame_buffer #(.DEPTH(1024), .FRAME_DEPTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_start(in_start), .in_data_valid(in_data_valid),
        .in_bytes_valid(in_bytes_valid), .in_data(in_data), .in_commit(in_commit),
        .in_drop(in_drop), .tx_ready(tx_ready), .tx_start(tx_start),
        .tx_data_valid(tx_data_valid), .tx_bytes_valid(tx_bytes_valid), .tx_data(tx_data),
        .buf_free(buf_free), .frames_pending(frames_pending),
        .perf_tx_frames(perf_tx_frames), .perf_tx_dropped(perf_tx_dropped)
    );

    ethernet_tx_frame_buffer #(.DEPTH(64), .FRAME_DEPTH(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .in_start(in_start), .in_data_valid(in_data_valid),
        .in_bytes_valid(in_bytes_valid), .in_data(in_data), .in_commit(in_commit),
        .in_drop(in_drop), .tx_ready(tx_ready), .tx_start(s_tx_start),
        .tx_data_valid(s_tx_data_valid), .tx_bytes_valid(s_tx_bytes_valid), .tx_data(s_tx_data),
        .buf_free(s_buf_free), .frames_pending(s_frames_pending),
        .perf_tx_frames(s_perf_tx_frames), .perf_tx_dropped(s_perf_tx_dropped)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int commit_cyc = 0;
    int start_cyc = 0;
    int viol = 0;
    int wsum = 0;
    int exp_frames = 0;
    int exp_dropped = 0;

    logic [34:0] exp_words[$];
    int          exp_lens[$];
    logic [34:0] rx_words[$];
    int          rx_lens[$];
    logic [34:0] s_words[$];
    int          s_starts = 0;

    int  cur_len = 0;
    int  idle_run = 0;
    bit  had_frame = 0;
    bit  prev_start = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Protocol monitor and frame capture for the large instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            cur_len = 0; idle_run = 0; had_frame = 0; prev_start = 0;
        end else begin
            if (tx_start && tx_data_valid) viol++;
            if (!tx_data_valid && (tx_data != 32'd0 || tx_bytes_valid != 3'd0)) viol++;
            if (prev_start && !tx_data_valid) viol++;
            if (tx_data_valid && cur_len == 0 && !prev_start) viol++;
            if (tx_start && had_frame && idle_run < 1) viol++;
            if (tx_start) start_cyc = cyc;
            if (tx_data_valid) begin
                rx_words.push_back({tx_bytes_valid, tx_data});
                cur_len++;
            end else if (cur_len > 0) begin
                rx_lens.push_back(cur_len);
                cur_len = 0; had_frame = 1; idle_run = 0;
            end
            if (!tx_data_valid && !tx_start) idle_run++;
            prev_start = tx_start;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (s_tx_start) s_starts++;
            if (s_tx_data_valid) s_words.push_back({s_tx_bytes_valid, s_tx_data});
        end
    end

    // mode: 0 commit on last word, 1 drop after, 2 commit after,
    //       3 leave uncommitted, 4 commit+drop on last word
    task automatic send_frame(input int n, input logic [2:0] last_bv, input int mode, input bit exp_sent);
        logic [34:0] q[$];
        if (n == 0) begin
            @(posedge clk); #1;
            in_start = 1'b1;
        end
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            in_start       = (i == 0);
            in_data_valid  = 1'b1;
            in_bytes_valid = (i == n - 1) ? last_bv : 3'd4;
            in_data        = $urandom;
            in_commit      = (i == n - 1) && (mode == 0 || mode == 4);
            in_drop        = (i == n - 1) && (mode == 4);
            if (in_commit) commit_cyc = cyc;
            q.push_back({in_bytes_valid, in_data});
        end
        @(posedge clk); #1;
        in_start = 1'b0; in_data_valid = 1'b0; in_bytes_valid = 3'd0; in_data = 32'd0;
        in_commit = (mode == 2); in_drop = (mode == 1);
        if (mode == 1 || mode == 2) begin
            @(posedge clk); #1;
            in_commit = 1'b0; in_drop = 1'b0;
        end
        if (exp_sent) begin
            foreach (q[i]) exp_words.push_back(q[i]);
            exp_lens.push_back(n);
            wsum += n;
        end
    endtask

    task automatic clear_q();
        exp_words.delete(); exp_lens.delete(); rx_words.delete(); rx_lens.delete();
    endtask

    task automatic wait_frames(input string tag, input int n, input int budget);
        int c = 0;
        while (rx_lens.size() < n && c < budget) begin
            @(negedge clk); c++;
        end
        check_eq({tag, "_done"}, rx_lens.size(), n);
        repeat (4) @(negedge clk);
    endtask

    task automatic compare_rx(input string tag);
        check_eq({tag, "_nframes"}, rx_lens.size(), exp_lens.size());
        for (int i = 0; i < exp_lens.size() && i < rx_lens.size(); i++)
            check_eq($sformatf("%s_len%0d", tag, i), rx_lens[i], exp_lens[i]);
        check_eq({tag, "_nwords"}, rx_words.size(), exp_words.size());
        for (int i = 0; i < exp_words.size() && i < rx_words.size(); i++)
            check_eq($sformatf("%s_w%0d", tag, i), rx_words[i], exp_words[i]);
    endtask

    task automatic check_status(input string tag);
        check_eq({tag, "_frames"}, perf_tx_frames, exp_frames);
        check_eq({tag, "_dropped"}, perf_tx_dropped, exp_dropped);
        check_eq({tag, "_buf_free"}, buf_free, 1024);
        check_eq({tag, "_pending"}, frames_pending, 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_q();
        wsum = 0; exp_frames = 0; exp_dropped = 0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int c;
        int pad;
        in_start = 0; in_data_valid = 0; in_bytes_valid = 0; in_data = 0;
        in_commit = 0; in_drop = 0; tx_ready = 0;
        repeat (3) @(negedge clk);
        check_eq("rst_tx_start", tx_start, 0);
        check_eq("rst_tx_valid", tx_data_valid, 0);
        check_eq("rst_tx_data", tx_data, 0);
        check_eq("rst_tx_bv", tx_bytes_valid, 0);
        check_eq("rst_small_buf_free", s_buf_free, 64);
        check_status("rst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Overflow on the 64-word instance: 70 words then commit is rolled back.
        send_frame(70, 3'd4, 2, 1'b0);
        repeat (4) @(negedge clk);
        check_eq("ovf_dropped", s_perf_tx_dropped, 1);
        check_eq("ovf_buf_free", s_buf_free, 64);
        check_eq("ovf_pending", s_frames_pending, 0);
        check_eq("ovf_no_start", s_starts, 0);
        exp_words.delete(); exp_lens.delete();
        send_frame(4, 3'd3, 0, 1'b1);
        tx_ready = 1'b1;
        c = 0;
        while (s_words.size() < 4 && c < 200) begin @(negedge clk); c++; end
        repeat (4) @(negedge clk);
        check_eq("ovf_starts", s_starts, 1);
        check_eq("ovf_nwords", s_words.size(), 4);
        for (int i = 0; i < 4 && i < s_words.size(); i++)
            check_eq($sformatf("ovf_w%0d", i), s_words[i], exp_words[i]);
        check_eq("ovf_frames", s_perf_tx_frames, 1);
        tx_ready = 1'b0;
        pulse_reset();

        // Single frame, commit-to-start latency of 2 cycles.
        tx_ready = 1'b1;
        send_frame(16, 3'd2, 0, 1'b1);
        wait_frames("single", 1, 200);
        compare_rx("single");
        check_eq("single_latency", start_cyc - commit_cyc, 2);
        exp_frames = 1;
        check_status("single");

        // Backpressure: three frames held while tx_ready is low.
        clear_q();
        tx_ready = 1'b0;
        send_frame(10, 3'd4, 0, 1'b1);
        send_frame(1, 3'd1, 0, 1'b1);
        send_frame(375, 3'd3, 0, 1'b1);
        repeat (5) @(negedge clk);
        check_eq("bp_quiet", rx_words.size(), 0);
        check_eq("bp_pending", frames_pending, 3);
        check_eq("bp_buf_free", buf_free, 1024 - 386);
        tx_ready = 1'b1;
        wait_frames("bp", 3, 2000);
        compare_rx("bp");
        exp_frames = 4;
        check_status("bp");

        // Drop paths: in_drop, zero-length commit, commit+drop together,
        // and an uncommitted frame discarded by the next in_start.
        clear_q();
        send_frame(20, 3'd4, 1, 1'b0);
        send_frame(0, 3'd0, 2, 1'b0);
        send_frame(6, 3'd4, 4, 1'b0);
        send_frame(5, 3'd4, 3, 1'b0);
        send_frame(8, 3'd1, 0, 1'b1);
        exp_dropped = 4;
        wait_frames("drop", 1, 200);
        compare_rx("drop");
        exp_frames = 5;
        check_status("drop");

        // Pad so the next frame starts at DEPTH-3, then overlap write and read.
        clear_q();
        pad = (1021 - (wsum % 1024) + 1024) % 1024;
        send_frame(pad, 3'd4, 0, 1'b1);
        wait_frames("pad", 1, 3000);
        send_frame(300, 3'd1, 0, 1'b1);
        send_frame(50, 3'd2, 0, 1'b1);
        wait_frames("wrap", 3, 3000);
        compare_rx("wrap");
        exp_frames = 8;
        check_status("wrap");

        // Reset during word 5 of a 12-word frame, with another frame queued.
        clear_q();
        send_frame(12, 3'd4, 0, 1'b0);
        send_frame(3, 3'd4, 0, 1'b0);
        c = 0;
        while (rx_words.size() < 5 && c < 200) begin @(negedge clk); c++; end
        check_eq("mid_valid", tx_data_valid, 1);
        check_eq("mid_pending", frames_pending, 1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", tx_data_valid, 0);
        check_eq("mid_rst_start", tx_start, 0);
        check_eq("mid_rst_data", tx_data, 0);
        check_eq("mid_rst_bv", tx_bytes_valid, 0);
        check_eq("mid_rst_pending", frames_pending, 0);
        check_eq("mid_rst_frames", perf_tx_frames, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_q();
        wsum = 0; exp_frames = 0; exp_dropped = 0;
        repeat (2) @(negedge clk);
        check_status("post_rst");
        send_frame(7, 3'd2, 0, 1'b1);
        wait_frames("post_rst_tx", 1, 200);
        compare_rx("post_rst_tx");
        exp_frames = 1;
        check_status("post_rst_tx");

        check_eq("protocol", viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ethernet_tx_frame_buffer.md
Name: ethernet_tx_frame_buffer

Overview:
Store-and-forward transmit buffer between the L2 frame encoder and a TriSpeedEthernetMAC or XGEthernetMAC, all in one clock domain.
Accepts frames on the start/data_valid/bytes_valid/data/commit/drop bus and holds each frame until it is committed.
Only complete, committed frames are released to the MAC, so the MAC is never starved mid-frame.
Dropped, overflowed and empty frames never reach the MAC.

Parameters:
DEPTH, 1024, data RAM depth in 32-bit words; power of 2; at least 2 max-size frames.
FRAME_DEPTH, 32, length-FIFO entries, i.e. the maximum number of committed frames queued; power of 2.

Ports:
clk  in  1  single clock; all logic on rising edge.
rst_n  in  1  asynchronous, active-low reset.
in_start  in  1  start of a new frame from the encoder.
in_data_valid  in  1  in_data/in_bytes_valid carry a word.
in_bytes_valid  in  3  valid bytes in the word, 1..4, left-aligned (MSB first).
in_data  in  32  frame data.
in_commit  in  1  current frame complete; queue it for transmit.
in_drop  in  1  discard the current frame.
tx_ready  in  1  MAC can accept a new frame start this cycle.
tx_start  out  1  one-cycle start-of-frame strobe to the MAC.
tx_data_valid  out  1  tx_data/tx_bytes_valid valid.
tx_bytes_valid  out  3  valid bytes in tx_data.
tx_data  out  32  frame data to the MAC.
buf_free  out  log2(DEPTH)+1  free words, counting uncommitted data.
frames_pending  out  log2(FRAME_DEPTH)+1  committed frames not yet started.
perf_tx_frames  out  64  frames fully sent to the MAC.
perf_tx_dropped  out  64  frames discarded by in_drop, overflow, length-FIFO full or zero length.

Behaviour:
- Reset: every output is 0; pointers, length FIFO and state are cleared; buf_free = DEPTH. Reset applies at once, even mid-frame; partial frames are lost and the MAC sees data_valid drop.
- Storage: 35-bit words {bytes_valid, data} in block RAM with a 1-cycle read.
- Pointers are log2(DEPTH)+1 bits with natural wrap:
  - wr_ptr: next write location.
  - commit_ptr: start of the frame currently being written.
  - rd_ptr: next read location.
- Fill level is wr_ptr - rd_ptr. Full when the fill level equals DEPTH.
- Write side:
  - in_start sets wr_ptr to commit_ptr, which implicitly discards any uncommitted frame. That discard counts as dropped only if the frame held at least 1 word. in_start also clears the overflow flag and the word counter.
  - in_data_valid while not full: write the word, wr_ptr+1, word count+1.
  - in_data_valid while full: set the overflow flag and do not write.
  - in_start and in_data_valid in the same cycle: the word is the first word of the new frame.
  - in_commit and in_data_valid in the same cycle: the word is included in the frame.
  - in_commit is accepted when overflow=0, word count >= 1 and the length FIFO is not full. It then pushes the word count into the length FIFO and sets commit_ptr to the new wr_ptr.
  - in_commit otherwise: rollback (wr_ptr = commit_ptr) and perf_tx_dropped+1.
  - in_drop: rollback and perf_tx_dropped+1.
  - in_commit and in_drop together: drop wins.
- Read FSM:
  - IDLE: if the length FIFO is non-empty and tx_ready=1, pop the length L, issue the RAM read at rd_ptr, go to START.
  - START: tx_start=1 for exactly this one cycle, issue the read at rd_ptr+1 if L>1, go to DATA.
  - DATA: tx_data_valid=1 with RAM data for L consecutive cycles, starting the cycle after tx_start. No gaps; the MAC may not backpressure mid-frame. rd_ptr increments per word read.
  - After the last word (when tx_data_valid was 1 for the L-th time), perf_tx_frames+1 and go to IDLE.
- Latency and pacing:
  - At least 1 idle cycle between frames.
  - Minimum latency from pending-and-ready to tx_start is 1 cycle.
  - Minimum latency from a committed frame with an idle FSM to tx_start is 2 cycles (the length FIFO is registered).
- Outputs when not streaming:
  - tx_bytes_valid and tx_data are 0 whenever tx_data_valid=0.
  - tx_start never coincides with tx_data_valid.
- Simultaneous events: a length-FIFO push and pop in the same cycle leaves frames_pending unchanged. Space freed by reads is visible to the writer on the next cycle.
- Status outputs: buf_free and frames_pending are registered with 1-cycle latency. Counters wrap at 2^64.

Test Plan:
- Single frame: start, 16 words with bytes_valid 4, last word bytes_valid 2, commit, tx_ready=1 -> tx_start 1 cycle, then 16 contiguous data_valid cycles with identical data and last bytes_valid=2; perf_tx_frames=1; buf_free returns to 1024.
- Backpressure: commit 3 frames of 10, 1 and 375 words with tx_ready=0 -> nothing on tx, frames_pending=3. Raise tx_ready -> frames emitted in order with exact lengths and an idle gap of at least 1 cycle between them.
- Drop/rollback: 20 words then in_drop, then a new 8-word frame committed -> only the 8-word frame is transmitted; perf_tx_dropped=1; buf_free=1024 after it is sent.
- Overflow: DEPTH=64, tx_ready=0, frame of 70 words then commit -> no frame sent, perf_tx_dropped=1, buf_free=64. A following 4-word frame is sent intact.
- Concurrency: stream a 300-word frame out while writing and committing the next frame; also hit the wrap boundary (start at wr_ptr=DEPTH-3) -> both frames bit-exact, no duplicated or missing words.
- Reset mid-transmit: assert rst_n=0 during word 5 of 12 -> all outputs 0 immediately. After release, buf_free=DEPTH, frames_pending=0, counters 0, and a new frame transmits normally.
